// File: rtl/game_state_ctrl.sv
// Game-flow controller: BEGIN/PLAY/PAUSE/LEVEL_CLEAR/WIN/LOSE with multi-level progression.
// Optional per-level play timer enabled by defining GAME_TIMER_EN (adds the time_up output).
module game_state_ctrl #(
  parameter int N_BLOCKS   = 50,
  parameter int HEALTH_W   = 4,
  parameter int N_LEVELS   = 3,
  parameter int CLEAR_HOLD = 100,
  parameter int TIME_LIMIT = 1000000,
  localparam int LVL_W     = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
  localparam int BL_W      = $clog2(N_BLOCKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic [HEALTH_W-1:0] health,
  input  logic [N_BLOCKS-1:0] bk_touched,
  output logic [1:0]          game_state,
  output logic                paused,
  output logic                clearing,
  output logic [LVL_W-1:0]    level,
  output logic                level_load,
  output logic [BL_W-1:0]     blocks_left,
`ifdef GAME_TIMER_EN
  output logic                time_up,
`endif
  output logic                state_chg
);

  localparam int HOLD_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_BEGIN = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BL_W-1:0]    blocks_left_q, blocks_left_d;
  logic [1:0]         game_state_q, game_state_d;
  logic               paused_q, paused_d;
  logic               clearing_q, clearing_d;
  logic               level_load_q, level_load_d;
  logic               state_chg_q, state_chg_d;
  logic               all_touched, last_level, health_dead;

  function automatic logic [BL_W-1:0] count_zeros(input logic [N_BLOCKS-1:0] v);
    logic [BL_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_BLOCKS; i++) n = n + BL_W'(!v[i]);
    return n;
  endfunction

  assign all_touched = &bk_touched;
  assign last_level  = (level_q == LVL_W'(N_LEVELS - 1));
  assign health_dead = (health == '0);

`ifdef GAME_TIMER_EN
  localparam int TMR_W = $clog2(TIME_LIMIT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             time_up_q, time_up_d;
  logic             timeout, timeout_lose;
  // Timeout fires on the PLAY edge that would complete the TIME_LIMIT-th play cycle.
  assign timeout = (timer_q == TMR_W'(TIME_LIMIT - 1));
`endif

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    hold_d       = hold_q;
    level_load_d = 1'b0;
`ifdef GAME_TIMER_EN
    timeout_lose = 1'b0;
`endif
    case (state_q)
      S_BEGIN: begin
        if (start) begin
          state_d      = S_PLAY;
          level_d      = '0;
          level_load_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (all_touched && last_level) begin
          state_d = S_WIN;
        end else if (all_touched) begin
          state_d = S_CLEAR;
          hold_d  = HOLD_W'(CLEAR_HOLD - 1);
        end else if (health_dead) begin
          state_d = S_LOSE;
`ifdef GAME_TIMER_EN
        end else if (timeout) begin
          state_d      = S_LOSE;
          timeout_lose = 1'b1;
`endif
        end else if (pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause) state_d = S_PLAY;
      end
      S_CLEAR: begin
        if (hold_q == '0) begin
          state_d      = S_PLAY;
          level_load_d = 1'b1;
          if (!last_level) level_d = level_q + LVL_W'(1);
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_BEGIN;
          level_d = '0;
        end
      end
      default: state_d = S_BEGIN;
    endcase

    case (state_d)
      S_BEGIN:                 game_state_d = 2'b00;
      S_WIN:                   game_state_d = 2'b11;
      S_LOSE:                  game_state_d = 2'b10;
      default:                 game_state_d = 2'b01;
    endcase
    paused_d      = (state_d == S_PAUSE);
    clearing_d    = (state_d == S_CLEAR);
    state_chg_d   = (state_d != state_q);
    blocks_left_d = count_zeros(bk_touched);

`ifdef GAME_TIMER_EN
    // Timer only advances in PLAY and restarts with each new level map.
    timer_d = timer_q;
    if (level_load_d || state_q == S_BEGIN) timer_d = '0;
    else if (state_q == S_PLAY)             timer_d = timer_q + TMR_W'(1);
    time_up_d = (state_d == S_LOSE) && (time_up_q || timeout_lose);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BEGIN;
      level_q       <= '0;
      hold_q        <= '0;
      blocks_left_q <= BL_W'(N_BLOCKS);
      game_state_q  <= 2'b00;
      paused_q      <= 1'b0;
      clearing_q    <= 1'b0;
      level_load_q  <= 1'b0;
      state_chg_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      hold_q        <= hold_d;
      blocks_left_q <= blocks_left_d;
      game_state_q  <= game_state_d;
      paused_q      <= paused_d;
      clearing_q    <= clearing_d;
      level_load_q  <= level_load_d;
      state_chg_q   <= state_chg_d;
    end
  end

`ifdef GAME_TIMER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      time_up_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      time_up_q <= time_up_d;
    end
  end
  assign time_up = time_up_q;
`endif

  assign game_state  = game_state_q;
  assign paused      = paused_q;
  assign clearing    = clearing_q;
  assign level       = level_q;
  assign level_load  = level_load_q;
  assign blocks_left = blocks_left_q;
  assign state_chg   = state_chg_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl (3 levels, 4-cycle clear hold, 50 blocks).
// The timer scenario is compiled only when GAME_TIMER_EN is defined.
module tb_game_state_ctrl;
  localparam int NB = 50;
  localparam int HW = 4;
  localparam int NL = 3;
  localparam int CH = 4;
  localparam int TL = 20;

  logic          clk = 1'b0;
  logic          reset, start, pause;
  logic [HW-1:0] health;
  logic [NB-1:0] bk_touched;
  logic [1:0]    game_state;
  logic          paused, clearing, level_load, state_chg;
  logic [1:0]    level;
  logic [5:0]    blocks_left;
`ifdef GAME_TIMER_EN
  logic          time_up;
`endif

  int checks = 0;
  int fails  = 0;

  game_state_ctrl #(
    .N_BLOCKS(NB), .HEALTH_W(HW), .N_LEVELS(NL), .CLEAR_HOLD(CH), .TIME_LIMIT(TL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .health(health),
    .bk_touched(bk_touched), .game_state(game_state), .paused(paused),
    .clearing(clearing), .level(level), .level_load(level_load),
    .blocks_left(blocks_left),
`ifdef GAME_TIMER_EN
    .time_up(time_up),
`endif
    .state_chg(state_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; health = 4'd5; bk_touched = '0;
    step(); step();
    checks++; if (game_state !== 2'b00) begin fails++; $display("FAIL rst_game_state: got %b want 00", game_state); end
    checks++; if (paused !== 1'b0 || clearing !== 1'b0) begin fails++; $display("FAIL rst_flags: got paused=%b clearing=%b want 0 0", paused, clearing); end
    checks++; if (level !== 2'd0 || level_load !== 1'b0 || state_chg !== 1'b0) begin fails++; $display("FAIL rst_level: got level=%0d load=%b chg=%b want 0 0 0", level, level_load, state_chg); end
    checks++; if (blocks_left !== 6'd50) begin fails++; $display("FAIL rst_blocks_left: got %0d want 50", blocks_left); end
`ifdef GAME_TIMER_EN
    checks++; if (time_up !== 1'b0) begin fails++; $display("FAIL rst_time_up: got %b want 0", time_up); end
`endif
    reset = 1'b0;
    step();
    checks++; if (game_state !== 2'b00) begin fails++; $display("FAIL idle_begin: got %b want 00", game_state); end
  endtask

  task automatic test_start();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (game_state !== 2'b01 || level !== 2'd0) begin fails++; $display("FAIL start_play: got gs=%b level=%0d want 01 0", game_state, level); end
    checks++; if (level_load !== 1'b1 || state_chg !== 1'b1) begin fails++; $display("FAIL start_pulses: got load=%b chg=%b want 1 1", level_load, state_chg); end
    checks++; if (blocks_left !== 6'd50) begin fails++; $display("FAIL start_blocks_left: got %0d want 50", blocks_left); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (level_load !== 1'b0 || state_chg !== 1'b0 || game_state !== 2'b01) begin fails++; $display("FAIL start_ignored_in_play: got load=%b chg=%b gs=%b want 0 0 01", level_load, state_chg, game_state); end
  endtask

  task automatic test_levels();
    for (int lv = 0; lv < 2; lv++) begin
      bk_touched = '1; step();
      checks++; if (clearing !== 1'b1 || state_chg !== 1'b1) begin fails++; $display("FAIL clear_entry_l%0d: got clearing=%b chg=%b want 1 1", lv, clearing, state_chg); end
      checks++; if (blocks_left !== 6'd0) begin fails++; $display("FAIL clear_blocks_left_l%0d: got %0d want 0", lv, blocks_left); end
      bk_touched = '0; pause = 1'b1;
      for (int c = 1; c < CH; c++) begin
        step(); pause = 1'b0;
        checks++; if (clearing !== 1'b1 || paused !== 1'b0 || game_state !== 2'b01) begin fails++; $display("FAIL clear_hold_l%0d_c%0d: got clearing=%b paused=%b gs=%b want 1 0 01", lv, c, clearing, paused, game_state); end
      end
      step();
      checks++; if (clearing !== 1'b0 || level !== 2'(lv + 1) || level_load !== 1'b1) begin fails++; $display("FAIL next_level_l%0d: got clearing=%b level=%0d load=%b want 0 %0d 1", lv, clearing, level, level_load, lv + 1); end
      step();
      checks++; if (level_load !== 1'b0 || game_state !== 2'b01) begin fails++; $display("FAIL load_one_cycle_l%0d: got load=%b gs=%b want 0 01", lv, level_load, game_state); end
    end
  endtask

  task automatic test_win_priority();
    health = 4'd0; bk_touched = '1; step();
    checks++; if (game_state !== 2'b11 || level !== 2'd2 || state_chg !== 1'b1) begin fails++; $display("FAIL win_beats_death: got gs=%b level=%0d chg=%b want 11 2 1", game_state, level, state_chg); end
    health = 4'd5; bk_touched = '0; pause = 1'b1; step(); pause = 1'b0;
    checks++; if (game_state !== 2'b11 || state_chg !== 1'b0 || paused !== 1'b0) begin fails++; $display("FAIL win_sticky: got gs=%b chg=%b paused=%b want 11 0 0", game_state, state_chg, paused); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (game_state !== 2'b00 || level !== 2'd0) begin fails++; $display("FAIL win_to_begin: got gs=%b level=%0d want 00 0", game_state, level); end
  endtask

  task automatic test_pause_lose();
    start = 1'b1; step(); start = 1'b0;
    pause = 1'b1; step(); pause = 1'b0;
    checks++; if (paused !== 1'b1 || game_state !== 2'b01) begin fails++; $display("FAIL pause_enter: got paused=%b gs=%b want 1 01", paused, game_state); end
    health = 4'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (paused !== 1'b1 || game_state !== 2'b01) begin fails++; $display("FAIL pause_frozen_%0d: got paused=%b gs=%b want 1 01", i, paused, game_state); end
    end
    pause = 1'b1; step(); pause = 1'b0;
    checks++; if (paused !== 1'b0 || game_state !== 2'b01) begin fails++; $display("FAIL resume: got paused=%b gs=%b want 0 01", paused, game_state); end
    step();
    checks++; if (game_state !== 2'b10) begin fails++; $display("FAIL lose_after_resume: got %b want 10", game_state); end
    health = 4'd5; start = 1'b1; step(); start = 1'b0;
    checks++; if (game_state !== 2'b00 || level !== 2'd0) begin fails++; $display("FAIL lose_to_begin: got gs=%b level=%0d want 00 0", game_state, level); end
  endtask

  task automatic test_blocks_and_async_reset();
    logic [NB-1:0] seven;
    seven = 50'h7F;
    bk_touched = seven; step();
    checks++; if (blocks_left !== 6'd43) begin fails++; $display("FAIL blocks_left_7: got %0d want 43", blocks_left); end
    bk_touched = '0; step();
    checks++; if (blocks_left !== 6'd50) begin fails++; $display("FAIL blocks_left_0: got %0d want 50", blocks_left); end
    start = 1'b1; step(); start = 1'b0;
    bk_touched = '1; step();
    checks++; if (clearing !== 1'b1) begin fails++; $display("FAIL pre_reset_clear: got %b want 1", clearing); end
    #2 reset = 1'b1;
    #1;
    checks++; if (game_state !== 2'b00 || clearing !== 1'b0 || level !== 2'd0) begin fails++; $display("FAIL async_reset: got gs=%b clearing=%b level=%0d want 00 0 0", game_state, clearing, level); end
    checks++; if (blocks_left !== 6'd50) begin fails++; $display("FAIL async_reset_blocks: got %0d want 50", blocks_left); end
    #2 reset = 1'b0;
    bk_touched = '0;
    step();
  endtask

`ifdef GAME_TIMER_EN
  task automatic test_timer();
    health = 4'd5; bk_touched = '0;
    start = 1'b1; step(); start = 1'b0;
    repeat (9) step();
    pause = 1'b1; step(); pause = 1'b0;
    checks++; if (paused !== 1'b1) begin fails++; $display("FAIL timer_pause: got %b want 1", paused); end
    repeat (49) step();
    pause = 1'b1; step(); pause = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (game_state !== 2'b01) begin fails++; $display("FAIL timer_still_play_%0d: got %b want 01", i, game_state); end
    end
    step();
    checks++; if (game_state !== 2'b10 || time_up !== 1'b1) begin fails++; $display("FAIL timeout_lose: got gs=%b time_up=%b want 10 1", game_state, time_up); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (time_up !== 1'b0 || game_state !== 2'b00) begin fails++; $display("FAIL time_up_clear: got time_up=%b gs=%b want 0 00", time_up, game_state); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_levels();
    test_win_priority();
    test_pause_lose();
    test_blocks_and_async_reset();
`ifdef GAME_TIMER_EN
    test_timer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Parametrised game-flow controller. Decides begin / playing / win / lose from the player's health and the block-touched vector.
- Adds multi-level progression, a pause toggle, a level-clear hold interval and a live count of remaining blocks.
- Sits between the game-logic modules (health counter, block collision map) and the VGA/render and map-loader modules.

Parameters:
- N_BLOCKS, 50, number of blocks per level; width of bk_touched.
- HEALTH_W, 4, width of health.
- N_LEVELS, 3, number of levels; the final level's clear gives a win. Must be >= 1.
- CLEAR_HOLD, 100, cycles spent in LEVEL_CLEAR before the next level starts. Must be >= 1.
- TIME_LIMIT, 1000000, per-level play-cycle budget. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to BEGIN.
- start  in  1  one-cycle pulse: starts the game from BEGIN, or returns to BEGIN from WIN/LOSE.
- pause  in  1  one-cycle pulse: toggles pause while playing.
- health  in  HEALTH_W  current player health; 0 means dead.
- bk_touched  in  N_BLOCKS  per-block touched flags for the current level.
- game_state  out  2  00 begin, 01 playing (PLAY/PAUSE/LEVEL_CLEAR), 11 win, 10 lose.
- paused  out  1  high in PAUSE.
- clearing  out  1  high in LEVEL_CLEAR.
- level  out  $clog2(N_LEVELS) (min 1)  current level index, 0-based.
- level_load  out  1  one-cycle pulse telling the map loader to load the map for `level`.
- blocks_left  out  $clog2(N_BLOCKS+1)  number of zero bits in bk_touched, registered.
- state_chg  out  1  one-cycle pulse on every internal-state change.

Behaviour:
- Reset values (asynchronous): state = BEGIN, game_state = 00, paused = 0, clearing = 0, level = 0, level_load = 0, blocks_left = N_BLOCKS, state_chg = 0.
- All outputs are registered. A state transition takes effect one cycle after the qualifying input is sampled.
- Internal states are BEGIN, PLAY, PAUSE, LEVEL_CLEAR, WIN, LOSE.
- BEGIN:
  - start = 1 -> PLAY, level = 0, level_load pulses in the same cycle as the entry.
- PLAY, checks in this priority:
  1. All bk_touched bits = 1 and level == N_LEVELS-1 -> WIN.
  2. All bk_touched bits = 1 otherwise -> LEVEL_CLEAR; the hold counter is loaded with CLEAR_HOLD-1.
  3. health == 0 -> LOSE.
  4. pause = 1 -> PAUSE.
  - Clear beats death on the same cycle.
- PAUSE:
  - Health and block checks are frozen.
  - pause = 1 -> PLAY. The checks resume on the next cycle, so health = 0 while paused gives LOSE one cycle after resume.
- LEVEL_CLEAR:
  - The hold counter decrements each cycle; pause and health are ignored.
  - At count 0 -> PLAY, level increments by 1, level_load pulses.
  - With CLEAR_HOLD = 1 the block spends exactly 1 cycle in LEVEL_CLEAR.
- WIN / LOSE:
  - Sticky. start = 1 -> BEGIN with level reset to 0. All other inputs are ignored.
- start is ignored in PLAY, PAUSE and LEVEL_CLEAR. pause is ignored outside PLAY/PAUSE.
- blocks_left:
  - Popcount of ~bk_touched, registered with 1-cycle latency. Updates in every state.
  - 0 only when all blocks are touched.
- state_chg pulses for exactly 1 cycle, coincident with the first cycle of the new state.
- level never exceeds N_LEVELS-1; there is no wrap-around.
- Reset asserted mid-game (any state) forces BEGIN immediately, without waiting for a clock edge.

Optional Feature:
- Macro: GAME_TIMER_EN.
- Defined:
  - A per-level play timer counts cycles spent in PLAY only; it does not count in PAUSE or LEVEL_CLEAR.
  - The timer clears on every level_load.
  - When it reaches TIME_LIMIT -> LOSE.
  - Priority: clear > health == 0 > timeout > pause.
  - Extra output `time_up` (1 bit, registered) is high in LOSE when the loss was caused by the timeout. Resets to 0.
- Undefined: no timer logic, no time_up port, TIME_LIMIT unused.

Test Plan:
- Reset, then start pulse with health = 5 and bk_touched = 0 -> next cycle game_state = 01, level = 0, level_load = 1 for exactly 1 cycle, blocks_left = 50.
- N_LEVELS = 3, CLEAR_HOLD = 4; set bk_touched = all ones at level 0 -> clearing = 1 for 4 cycles, then level = 1 with a level_load pulse. Repeat twice -> game_state = 11 after the level-2 clear.
- In PLAY, on the same cycle set health = 0 and bk_touched = all ones at level 2 -> game_state = 11, not 10.
- Pause pulse, then health = 0 for 10 cycles -> game_state stays 01 with paused = 1. Pause pulse again -> LOSE 1 cycle after resume, game_state = 10. Start pulse -> game_state = 00, level = 0.
- Set 7 bits of bk_touched to 1 -> blocks_left = 43 one cycle later. Assert reset mid-LEVEL_CLEAR -> game_state = 00 and clearing = 0 immediately, with no clock edge.
- With GAME_TIMER_EN defined and TIME_LIMIT = 20: play 10 cycles, pause 50 cycles, resume -> LOSE after 10 more PLAY cycles, time_up = 1.
